// File: rtl/cdc_src_if.sv
// rtl/cdc_src_if.sv - upstream valid/ready payload stream into the CDC source.
interface cdc_src_if #(
  parameter type T = logic
);
  logic valid;
  T     data;
  logic ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/cdc_src.sv
// rtl/cdc_src.sv - source half of a two-phase toggle req/ack clock-domain crossing.
module cdc_src #(
  parameter type         T     = logic,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  cdc_src_if.slave         src,
  output logic             async_req_o,
  output T                 async_data_o,
  input  logic             async_ack_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] tx_count_o
);

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    IDLE     = 2'd1,
    WAIT_ACK = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             req_q, req_d;
  T                 data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_s1_q, ack_s2_q;

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    req_d   = req_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      IDLE: begin
        if (src.valid) begin
          data_d  = src.data;
          req_d   = ~req_q;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // Levels match once the destination has toggled ack for this request.
        if (ack_s2_q == req_q) begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: begin
        state_d = INIT;
        ready_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= INIT;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      req_q    <= 1'b0;
      data_q   <= '0;
      cnt_q    <= '0;
      ack_s1_q <= 1'b0;
      ack_s2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      req_q    <= req_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      ack_s1_q <= async_ack_i;
      ack_s2_q <= ack_s1_q;
    end
  end

  assign src.ready    = ready_q;
  assign async_req_o  = req_q;
  assign async_data_o = data_q;
  assign busy_o       = busy_q;
  assign tx_count_o   = cnt_q;

`ifndef SYNTHESIS
  // An ack toggle with no request outstanding means the two sides lost lockstep.
  spurious_ack_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == IDLE) |-> (ack_s2_q == req_q));
`endif

endmodule

// File: tb/tb_cdc_src.sv
// tb/tb_cdc_src.sv - directed bench for cdc_src with a hand-driven destination ack.
module tb_cdc_src;

  typedef logic [7:0] byte_t;
  localparam int CNT_W = 2;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             async_req_o;
  byte_t            async_data_o;
  logic             async_ack_i;
  logic             busy_o;
  logic [CNT_W-1:0] tx_count_o;

  int checks = 0;
  int errors = 0;
  int n;

  cdc_src_if #(.T(byte_t)) up_if ();

  cdc_src #(.T(byte_t), .CNT_W(CNT_W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .src         (up_if),
    .async_req_o (async_req_o),
    .async_data_o(async_data_o),
    .async_ack_i (async_ack_i),
    .busy_o      (busy_o),
    .tx_count_o  (tx_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Edges until ready_o rises, 99 if it never does within the budget.
  task automatic wait_ready(output int edges);
    edges = 0;
    do begin
      tick();
      edges++;
    end while (!up_if.ready && edges < 8);
    if (!up_if.ready) edges = 99;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni        = 1'b0;
    up_if.valid   = 1'b0;
    up_if.data    = 8'h00;
    async_ack_i   = 1'b0;
    repeat (3) tick();
    chk("rst_ready", up_if.ready, 0);
    chk("rst_req", async_req_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_cnt", tx_count_o, 0);
    chk("rst_data", async_data_o, 0);

    rst_ni = 1'b1;
    #1;
    chk("init_ready", up_if.ready, 0);
    tick();
    chk("idle_ready", up_if.ready, 1);
    chk("idle_req", async_req_o, 0);
    chk("idle_cnt", tx_count_o, 0);

    up_if.valid = 1'b1;
    up_if.data  = 8'hA5;
    tick();
    chk("single_req", async_req_o, 1);
    chk("single_data", async_data_o, 8'hA5);
    chk("single_ready", up_if.ready, 0);
    chk("single_busy", busy_o, 1);
    up_if.valid = 1'b0;
    up_if.data  = 8'h00;
    async_ack_i = 1'b1;
    tick();
    chk("lat_edge1_ready", up_if.ready, 0);
    tick();
    chk("lat_edge2_ready", up_if.ready, 0);
    tick();
    chk("lat_edge3_ready", up_if.ready, 1);
    chk("single_cnt", tx_count_o, 1);
    chk("single_busy_done", busy_o, 0);

    rst_ni      = 1'b0;
    async_ack_i = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    chk("rerst_ready", up_if.ready, 1);
    chk("rerst_cnt", tx_count_o, 0);

    up_if.valid = 1'b1;
    up_if.data  = 8'd1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("b2b%0d_req", i), async_req_o, i % 2);
      chk($sformatf("b2b%0d_data", i), async_data_o, i);
      chk($sformatf("b2b%0d_ready", i), up_if.ready, 0);
      up_if.data  = (i < 5) ? byte_t'(i + 1) : 8'h55;
      up_if.valid = (i < 5);
      async_ack_i = ~async_ack_i;
      wait_ready(n);
      chk($sformatf("b2b%0d_latency", i), n, 3);
      chk($sformatf("b2b%0d_hold", i), async_data_o, i);
      chk($sformatf("b2b%0d_cnt", i), tx_count_o, i % 4);
    end

    tick();
    tick();
    chk("idlehold_ready", up_if.ready, 1);
    chk("idlehold_req", async_req_o, 1);
    chk("idlehold_data", async_data_o, 8'd5);
    chk("idlehold_cnt", tx_count_o, 1);
    chk("idlehold_busy", busy_o, 0);

    rst_ni      = 1'b0;
    async_ack_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    up_if.valid = 1'b1;
    up_if.data  = 8'h3C;
    tick();
    chk("mid_req_before", async_req_o, 1);
    chk("mid_busy_before", busy_o, 1);
    up_if.valid = 1'b0;
    #2;
    rst_ni      = 1'b0;
    async_ack_i = 1'b0;
    #1;
    chk("mid_req_async", async_req_o, 0);
    chk("mid_ready_async", up_if.ready, 0);
    chk("mid_busy_async", busy_o, 0);
    chk("mid_data_async", async_data_o, 0);
    tick();
    rst_ni = 1'b1;
    tick();
    chk("post_ready", up_if.ready, 1);
    up_if.valid = 1'b1;
    up_if.data  = 8'h5A;
    tick();
    chk("post_req", async_req_o, 1);
    chk("post_data", async_data_o, 8'h5A);
    up_if.valid = 1'b0;
    async_ack_i = 1'b1;
    wait_ready(n);
    chk("post_latency", n, 3);
    chk("post_cnt", tx_count_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
